// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit at or after start, wrapping around.
// Purely combinational, no backpressure of its own.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx,
  output logic          win_vld
);

  int j;

  // Scan farthest-first so the requester nearest to start overwrites the rest.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        win_idx = IW'(j);
        win_vld = 1'b1;
      end
    end
    win_oh = win_vld ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, credit-gated arbiter driving one FIFO write port; grant in t, write strobe in t+1.
// Requesters are held off (gnt=0) when credits run out; reads of a non-empty FIFO return credits.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           gnt,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_din,
  input  logic                       fifo_rd_en,
  input  logic                       fifo_empty,
  input  logic                       fifo_full,
  output logic [cred_w(DEPTH)-1:0]   credits,
  output logic                       busy,
  output logic                       err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = cred_w(DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [BW-1:0]   burst_cnt, burst_cnt_nxt;
  logic [IW-1:0]   pick_start, win_idx, gnt_idx;
  logic [N_REQ-1:0] win_oh;
  logic            win_vld, has_credit, hold, gnt_any, ret;

  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // After a burst the old owner is searched last.
  assign pick_start = (state == ARB_BURST) ? inc_idx(owner) : rr_ptr;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req     (req),
    .start   (pick_start),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  assign has_credit = (credits != '0);
  assign hold = (state == ARB_BURST) && req[owner] && has_credit &&
                (int'(burst_cnt) < MAX_BURST);
  assign ret  = fifo_rd_en && !fifo_empty;
  assign busy = (state == ARB_BURST);

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    gnt_any       = 1'b0;
    gnt_idx       = owner;
    if (hold) begin
      gnt_any       = 1'b1;
      burst_cnt_nxt = burst_cnt + 1'b1;
    end else begin
      if (state == ARB_BURST) begin
        rr_ptr_nxt = inc_idx(owner);
        state_nxt  = ARB_IDLE;
      end
      if (win_vld && has_credit) begin
        gnt_any       = 1'b1;
        gnt_idx       = win_idx;
        owner_nxt     = win_idx;
        burst_cnt_nxt = BW'(1);
        if (MAX_BURST > 1) begin
          state_nxt = ARB_BURST;
        end else begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = inc_idx(win_idx);
        end
      end
    end
    gnt = (gnt_any && rst) ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      burst_cnt  <= '0;
      credits    <= CW'(DEPTH);
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      rr_ptr     <= rr_ptr_nxt;
      burst_cnt  <= burst_cnt_nxt;
      fifo_wr_en <= gnt_any;
      if (gnt_any) fifo_din <= req_data[int'(gnt_idx)*WIDTH +: WIDTH];
      // A return at full credit is illegal; saturate and flag it instead.
      if (gnt_any && !ret)
        credits <= credits - 1'b1;
      else if (!gnt_any && ret && credits != CW'(DEPTH))
        credits <= credits + 1'b1;
      if ((fifo_wr_en && fifo_full) || (ret && credits == CW'(DEPTH)))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with hand-computed expectations.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic        fifo_rd_en, fifo_empty, fifo_full;
  logic [3:0]  credits;
  logic        busy, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(4), .WIDTH(8), .DEPTH(8), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_rd_en (fifo_rd_en),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .credits    (credits),
    .busy       (busy),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  int exp_g[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  int ngnt;

  initial begin
    rst = 1'b0; req = '0; req_data = '0;
    fifo_rd_en = 1'b0; fifo_empty = 1'b1; fifo_full = 1'b0;
    tick(); tick();
    req = 4'b1111;
    #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_credits", credits, 8);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_din", fifo_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    req = '0;

    // single requester, four back-to-back grants
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req = 4'b0001;
      req_data[7:0] = 8'h11 + 8'(k);
      #1;
      chk("single_gnt", gnt, 4'b0001);
      tick();
      chk("single_wr_en", fifo_wr_en, 1);
      chk("single_din", fifo_din, 32'h11 + k);
      chk("single_credits", credits, 8 - (k + 1));
    end
    req = '0;
    tick();
    chk("single_idle_wr_en", fifo_wr_en, 0);
    chk("single_end_credits", credits, 4);
    chk("single_end_busy", busy, 0);

    // burst rotation between requesters 0 and 1
    do_reset();
    req_data = 32'hD3C2B1A0;
    req = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      fifo_rd_en = (k >= 1);
      fifo_empty = (k < 1);
      #1;
      chk("rot_gnt", gnt, 32'(1) << exp_g[k]);
      tick();
      chk("rot_busy", busy, 1);
      chk("rot_din", fifo_din, 32'hA0 + 32'h11 * exp_g[k]);
    end
    chk("rot_credits", credits, 7);
    req = '0; fifo_rd_en = 1'b0; fifo_empty = 1'b1;
    tick();

    // credit exhaustion
    do_reset();
    req = 4'b1111;
    ngnt = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (gnt != 0) ngnt++;
      tick();
    end
    chk("exh_count", ngnt, 8);
    chk("exh_gnt", gnt, 0);
    chk("exh_credits", credits, 0);
    fifo_full = 1'b1; fifo_empty = 1'b0;
    tick();
    chk("exh_err", err, 0);
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0; fifo_full = 1'b0;
    chk("exh_ret_credits", credits, 1);
    #1;
    chk("exh_ret_gnt", gnt, 4'b0100);
    tick();
    chk("exh_after_credits", credits, 0);
    #1;
    chk("exh_after_gnt", gnt, 0);

    // simultaneous grant and return
    req = '0; fifo_rd_en = 1'b1;
    tick(); tick(); tick();
    chk("sim_pre_credits", credits, 3);
    req = 4'b0001;
    #1;
    chk("sim_gnt", gnt, 4'b0001);
    tick();
    chk("sim_credits", credits, 3);
    req = '0; fifo_empty = 1'b1;
    tick();
    chk("empty_rd_credits", credits, 3);
    chk("sim_err", err, 0);
    fifo_rd_en = 1'b0;

    // reset in the middle of a burst
    req = 4'b0100;
    #1;
    chk("mid_gnt1", gnt, 4'b0100);
    tick();
    #1;
    chk("mid_gnt2", gnt, 4'b0100);
    rst = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    tick();
    chk("mid_wr_en", fifo_wr_en, 0);
    chk("mid_credits", credits, 8);
    chk("mid_busy", busy, 0);
    rst = 1'b1;
    req = 4'b1010;
    #1;
    chk("mid_ptr_gnt", gnt, 4'b0010);
    tick();

    // error injection and stickiness
    chk("err_wr_en", fifo_wr_en, 1);
    fifo_full = 1'b1; req = '0;
    tick();
    chk("err_set", err, 1);
    fifo_full = 1'b0;
    tick();
    chk("err_sticky", err, 1);
    do_reset();
    chk("err_cleared", err, 0);
    fifo_rd_en = 1'b1; fifo_empty = 1'b0;
    tick();
    fifo_rd_en = 1'b0;
    chk("err_overreturn", err, 1);
    chk("err_overreturn_credits", credits, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter sharing one parameterized FIFO write port between N_REQ producers. Tracks FIFO occupancy with an internal credit counter (one credit per free entry) so grants never overflow the FIFO, despite a registered write stage. Supports bounded bursts: a winning requester may hold the port for up to MAX_BURST consecutive writes before rotation. Sits directly in front of the fifo write side; the FIFO's consumer read strobe and empty flag return credits.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 8, data width, matches FIFO WIDTH
DEPTH, 8, FIFO depth = initial/maximum credit count
MAX_BURST, 4, max consecutive grants to one requester (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
req  input  N_REQ  per-requester write request, data valid with it
req_data  input  N_REQ*WIDTH  packed data, requester i at [i*WIDTH +: WIDTH]
gnt  output  N_REQ  one-hot or zero; gnt[i]=1 means req_data[i] accepted this cycle
fifo_wr_en  output  1  registered write strobe to FIFO
fifo_din  output  WIDTH  registered write data to FIFO
fifo_rd_en  input  1  FIFO consumer read strobe (observed only)
fifo_empty  input  1  FIFO empty flag
fifo_full  input  1  FIFO full flag (checking only)
credits  output  clog2(DEPTH+1)  current free-entry count
busy  output  1  1 while a burst owner is held
err  output  1  sticky protocol error

Behaviour:
- Reset (rst=0 at posedge): credits=DEPTH, fifo_wr_en=0, fifo_din=0, busy=0, err=0, rr pointer=0, burst count=0, owner=0. gnt forced 0 combinationally while rst=0.
- gnt is combinational from req, credits, state. A grant requires credits>0. At most one bit set.
- Latency: grant in cycle t -> fifo_wr_en=1 and fifo_din=req_data[i] in cycle t+1. FIFO writes at end of t+1. No bubble between back-to-back grants.
- Credits: decrement at end of any cycle with a grant. Increment at end of any cycle with fifo_rd_en && !fifo_empty. Both together: unchanged. Returned credits are not usable in the same cycle.
- States:
  - IDLE: choose the first i with req[i]=1, searching from the rr pointer upward with wrap-around. Grant it. owner=i, burst count=1, go to BURST unless MAX_BURST=1.
  - BURST: if req[owner] && credits>0 && burst count<MAX_BURST, grant owner and increment burst count.
  - Otherwise the burst ends. Arbitrate the same cycle as in IDLE, with the pointer set to (owner+1) mod N_REQ; the old owner is eligible only after the others are searched.
- Any burst end sets the rr pointer to (owner+1) mod N_REQ. busy=1 exactly while in BURST.
- credits=0: no grant; state returns to IDLE with the pointer advanced past owner.
- err sets and holds until reset on:
  - fifo_wr_en=1 while fifo_full=1
  - credit return while credits==DEPTH
- Reset mid-burst: owner, count, pointer and credits reinitialised; the in-flight registered write is dropped (fifo_wr_en=0 next cycle).
- Requesters must hold req/data until granted. Dropping req before grant is legal and is not an error.

Decomposition:
- Shared package fifo_arb_pkg:
  - state enum {ARB_IDLE, ARB_BURST}
  - function for clog2-based credit width
- One sub-module, rr_pick: combinational round-robin priority picker; inputs req vector and start pointer; outputs one-hot winner, index and valid.
- Credit counter, burst FSM and output registers stay in fifo_wr_arbiter.

Test Plan:
- Reset then single requester: req=4'b0001, data 0x11..0x14, no reads -> gnt[0] on 4 consecutive cycles; fifo_wr_en 1 cycle later with the same data; credits 8->4.
- Burst rotation: req=4'b0011 held, ample credits -> grants 0,0,0,0,1,1,1,1,0... (MAX_BURST=4); pointer wraps; busy=1 throughout.
- Credit exhaustion: req=4'b1111, no reads -> exactly 8 grants, then gnt=0, credits=0, fifo_full=1, err=0. One fifo_rd_en with fifo_empty=0 -> credits=1 next cycle and exactly one more grant.
- Simultaneous grant and read at credits=3 -> credits stays 3. fifo_rd_en with fifo_empty=1 -> credits unchanged.
- Reset mid-burst: assert rst=0 during the owner's 2nd grant -> next cycle gnt=0, fifo_wr_en=0, credits=8, busy=0; after release, the pointer starts at 0.
- Error injection: drive fifo_full=1 while fifo_wr_en=1 -> err=1 and stays 1 until rst=0.
